// File: rtl/periph_bridge_pkg.sv
// rtl/periph_bridge_pkg.sv - shared types for the peripheral bus bridge
// Contents: FSM state enum, byte-phase type, queued transaction struct.
package periph_bridge_pkg;

  // Widest register number a queued transaction can carry; REG_W must not exceed it.
  localparam int MAX_REG_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_RECOVER
  } state_t;

  typedef enum logic {
    PH_HI,
    PH_LO
  } phase_t;

  typedef struct packed {
    logic [MAX_REG_W-1:0] reg_num;
    logic [15:0]          data;
  } xact_t;

endpackage

// File: rtl/bridge_fifo.sv
// rtl/bridge_fifo.sv - posted-write queue of bridge transactions
// Ports: clk, reset_n (async, active-low); push/push_data write side;
//        pop/pop_data read side (pop_data is the stored head entry);
//        full, empty, count derived from the registered occupancy.
module bridge_fifo
  import periph_bridge_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  xact_t            push_data,
  input  logic             pop,
  output xact_t            pop_data,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  xact_t            mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  // Storage carries no reset: only entries below count are ever observed.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign pop_data = mem[rd_ptr];
  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);

endmodule

// File: rtl/periph_bus_bridge.sv
// rtl/periph_bus_bridge.sv - CPU to byte-wide peripheral bus bridge with posted writes
// Ports: clk, reset_n (async, active-low);
//        cpu_sel/cpu_write/cpu_addr/cpu_wdata in, cpu_rdata/cpu_hold out;
//        bus_cs_n_o, bus_rd_nwr_o, bus_bytesel_o, bus_reg_num_o, bus_data_o out,
//        bus_data_i in; busy_o out.
module periph_bus_bridge
  import periph_bridge_pkg::*;
#(
  parameter int REG_W      = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int SETUP_CYC  = 1,
  parameter int STROBE_CYC = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cpu_sel,
  input  logic             cpu_write,
  input  logic [REG_W:0]   cpu_addr,
  input  logic [15:0]      cpu_wdata,
  output logic [15:0]      cpu_rdata,
  output logic             cpu_hold,
  output logic             bus_cs_n_o,
  output logic             bus_rd_nwr_o,
  output logic             bus_bytesel_o,
  output logic [REG_W-1:0] bus_reg_num_o,
  output logic [7:0]       bus_data_o,
  input  logic [7:0]       bus_data_i,
  output logic             busy_o
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  state_t           state;
  phase_t           phase;
  logic [7:0]       cnt;
  logic [7:0]       lo_byte;
  logic [15:0]      rdata_q;

  xact_t            in_x;
  xact_t            head;
  logic             push, pop, full, empty;
  logic [CNT_W-1:0] count;

  logic             wr_req, rd_req, status_sel;
  logic             rec_lo, rd_done, start_write, start_read;
  logic             unused_reg_bits;

  assign status_sel = cpu_sel &  cpu_addr[REG_W];
  assign wr_req     = cpu_sel & ~cpu_addr[REG_W] &  cpu_write;
  assign rd_req     = cpu_sel & ~cpu_addr[REG_W] & ~cpu_write;

  assign rec_lo  = (state == ST_RECOVER) && (phase == PH_LO);
  // The only bus read ever started is the one the stalled CPU is waiting on.
  assign rd_done = rec_lo && bus_rd_nwr_o;

  // A new word may start from IDLE or straight out of the last recover cycle.
  // Queued writes always win, which keeps every posted write ahead of a read.
  assign start_write = !empty && ((state == ST_IDLE) || rec_lo);
  assign start_read  = empty && rd_req &&
                       ((state == ST_IDLE) || (rec_lo && !bus_rd_nwr_o));

  assign push     = wr_req && !full;
  assign pop      = start_write;
  assign cpu_hold = (wr_req && full) || (rd_req && !rd_done);
  assign busy_o   = !empty || (state != ST_IDLE);

  always_comb begin
    in_x         = '0;
    in_x.reg_num = MAX_REG_W'(cpu_addr[REG_W-1:0]);
    in_x.data    = cpu_wdata;
  end

  // Status reads are answered combinationally; data reads show the captured word.
  assign cpu_rdata = status_sel ? {8'(count), 6'b0, full, busy_o} : rdata_q;

  assign unused_reg_bits = ^head.reg_num;

  bridge_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push),
    .push_data (in_x),
    .pop       (pop),
    .pop_data  (head),
    .full      (full),
    .empty     (empty),
    .count     (count)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= ST_IDLE;
      phase         <= PH_HI;
      cnt           <= '0;
      bus_cs_n_o    <= 1'b1;
      bus_rd_nwr_o  <= 1'b1;
      bus_bytesel_o <= 1'b0;
      bus_reg_num_o <= '0;
      bus_data_o    <= '0;
      lo_byte       <= '0;
      rdata_q       <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_RECOVER: begin
          cnt <= '0;
          if ((state == ST_RECOVER) && (phase == PH_HI)) begin
            phase         <= PH_LO;
            bus_bytesel_o <= 1'b0;
            bus_data_o    <= lo_byte;
            state         <= ST_SETUP;
          end else if (start_write) begin
            phase         <= PH_HI;
            bus_rd_nwr_o  <= 1'b0;
            bus_bytesel_o <= 1'b1;
            bus_reg_num_o <= head.reg_num[REG_W-1:0];
            bus_data_o    <= head.data[15:8];
            lo_byte       <= head.data[7:0];
            state         <= ST_SETUP;
          end else if (start_read) begin
            phase         <= PH_HI;
            bus_rd_nwr_o  <= 1'b1;
            bus_bytesel_o <= 1'b1;
            bus_reg_num_o <= cpu_addr[REG_W-1:0];
            bus_data_o    <= '0;
            lo_byte       <= '0;
            state         <= ST_SETUP;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_SETUP: begin
          if (cnt == 8'(SETUP_CYC - 1)) begin
            cnt        <= '0;
            bus_cs_n_o <= 1'b0;
            state      <= ST_STROBE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_STROBE: begin
          if (cnt == 8'(STROBE_CYC - 1)) begin
            cnt        <= '0;
            bus_cs_n_o <= 1'b1;
            state      <= ST_RECOVER;
            // Peripheral data is sampled at the end of the final strobe cycle.
            if (bus_rd_nwr_o) begin
              if (phase == PH_HI) rdata_q[15:8] <= bus_data_i;
              else                rdata_q[7:0]  <= bus_data_i;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
